servo_scale_arbiter: RTL and testbench

SERVO_SCALE_ARBITER -- requirements
Module: servo_scale_arbiter

---
 rtl/servo_scale_arbiter.sv | 178 +++++++++++++++++
 tb/tb_servo_scale_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_scale_arbiter.sv
// rtl/servo_scale_arbiter.sv - two-channel round-robin range scaler sharing one external divider
module servo_scale_arbiter #(
  parameter int g_Old_Max     = 180,
  parameter int g_Old_Min     = 0,
  parameter int g_New_Max     = 15,
  parameter int g_New_Min     = 0,
  parameter int g_Div_Timeout = 64
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Req_A,
  input  logic        i_Req_B,
  input  logic [7:0]  i_Value_A,
  input  logic [7:0]  i_Value_B,
  output logic        o_Ack_A,
  output logic        o_Ack_B,
  output logic        o_Div_Start,
  output logic [11:0] o_Dividend,
  output logic [11:0] o_Divisor,
  input  logic        i_Div_Done,
  input  logic [11:0] i_Quotient,
  output logic [3:0]  o_Result_A,
  output logic [3:0]  o_Result_B,
  output logic        o_Valid_A,
  output logic        o_Valid_B,
  output logic        o_Busy,
  output logic        o_Timeout
);

  localparam int OLD_SPAN = g_Old_Max - g_Old_Min;
  localparam int NEW_SPAN = g_New_Max - g_New_Min;
  localparam int CNT_W    = $clog2(g_Div_Timeout + 1);

  localparam logic [11:0]      DIVISOR   = 12'(OLD_SPAN);
  localparam logic [11:0]      SCALE_K   = 12'(NEW_SPAN);
  localparam logic [11:0]      OLD_MAX_W = 12'(g_Old_Max);
  localparam logic [11:0]      OLD_MIN_W = 12'(g_Old_Min);
  localparam logic [12:0]      NEW_MAX_W = 13'(g_New_Max);
  localparam logic [12:0]      NEW_MIN_W = 13'(g_New_Min);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(g_Div_Timeout - 1);

  // Reject parameter sets whose scaled product would overflow the 12-bit dividend.
  generate
    if (g_Old_Max <= g_Old_Min || g_New_Max < g_New_Min || g_New_Max > 15 ||
        OLD_SPAN * NEW_SPAN > 4095 || g_Div_Timeout < 1) begin : g_param_check
      $error("servo_scale_arbiter: invalid parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    OFFSET,
    SCALE,
    START,
    WAIT,
    FINISH
  } state_t;

  state_t           state;
  logic             last_b;    // last channel served was B
  logic             chan_b;    // channel currently being converted is B
  logic [7:0]       value_q;
  logic [11:0]      offset_q;
  logic [11:0]      quot_q;
  logic [CNT_W-1:0] wait_cnt;

  logic [11:0] value_w;
  logic [11:0] clamped;
  logic [12:0] below_min;
  logic [12:0] sum_w;
  logic [3:0]  scaled;

  // Clamp the latched raw value into the input range; borrow bit flags "below minimum".
  always_comb begin
    value_w   = {4'b0000, value_q};
    below_min = {1'b0, value_w} - {1'b0, OLD_MIN_W};
    clamped   = value_w;
    if (value_w > OLD_MAX_W) begin
      clamped = OLD_MAX_W;
    end else if (below_min[12]) begin
      clamped = OLD_MIN_W;
    end
  end

  // Shift the quotient into the output range and saturate at the top.
  always_comb begin
    sum_w  = {1'b0, quot_q} + NEW_MIN_W;
    scaled = sum_w[3:0];
    if (sum_w > NEW_MAX_W) begin
      scaled = NEW_MAX_W[3:0];
    end
  end

  assign o_Busy = (state != IDLE);

  // Arbitration and conversion sequencer; every output is a registered product of the state it leaves.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      chan_b      <= 1'b0;
      value_q     <= '0;
      offset_q    <= '0;
      quot_q      <= '0;
      wait_cnt    <= '0;
      o_Ack_A     <= 1'b0;
      o_Ack_B     <= 1'b0;
      o_Div_Start <= 1'b0;
      o_Dividend  <= '0;
      o_Divisor   <= '0;
      o_Result_A  <= '0;
      o_Result_B  <= '0;
      o_Valid_A   <= 1'b0;
      o_Valid_B   <= 1'b0;
      o_Timeout   <= 1'b0;
    end else begin
      o_Ack_A     <= 1'b0;
      o_Ack_B     <= 1'b0;
      o_Div_Start <= 1'b0;
      o_Valid_A   <= 1'b0;
      o_Valid_B   <= 1'b0;
      o_Timeout   <= 1'b0;
      o_Divisor   <= DIVISOR;
      case (state)
        IDLE: begin
          if (i_Req_A && (!i_Req_B || last_b)) begin
            chan_b  <= 1'b0;
            value_q <= i_Value_A;
            o_Ack_A <= 1'b1;
            state   <= OFFSET;
          end else if (i_Req_B) begin
            chan_b  <= 1'b1;
            value_q <= i_Value_B;
            o_Ack_B <= 1'b1;
            state   <= OFFSET;
          end
        end
        OFFSET: begin
          offset_q <= clamped - OLD_MIN_W;
          state    <= SCALE;
        end
        SCALE: begin
          o_Dividend <= offset_q * SCALE_K;
          state      <= START;
        end
        START: begin
          o_Div_Start <= 1'b1;
          wait_cnt    <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          if (i_Div_Done) begin
            quot_q <= i_Quotient;
            state  <= FINISH;
          end else if (wait_cnt == CNT_LAST) begin
            o_Timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FINISH: begin
          if (chan_b) begin
            o_Result_B <= scaled;
            o_Valid_B  <= 1'b1;
          end else begin
            o_Result_A <= scaled;
            o_Valid_A  <= 1'b1;
          end
          last_b <= chan_b;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_scale_arbiter.sv
// tb/tb_servo_scale_arbiter.sv - directed vector bench for servo_scale_arbiter
module tb_servo_scale_arbiter;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic        i_Req_A = 1'b0;
  logic        i_Req_B = 1'b0;
  logic [7:0]  i_Value_A = '0;
  logic [7:0]  i_Value_B = '0;
  logic        o_Ack_A, o_Ack_B, o_Div_Start;
  logic [11:0] o_Dividend, o_Divisor;
  logic        i_Div_Done;
  logic [11:0] i_Quotient;
  logic [3:0]  o_Result_A, o_Result_B;
  logic        o_Valid_A, o_Valid_B, o_Busy, o_Timeout;

  logic        div_auto = 1'b1;
  logic [11:0] div_q = '0;
  logic        auto_done = 1'b0;
  logic [11:0] auto_q = '0;
  logic        man_done = 1'b0;
  logic [11:0] man_q = '0;

  assign i_Div_Done = auto_done | man_done;
  assign i_Quotient = auto_done ? auto_q : man_q;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_res_a = '0;
  logic [3:0] exp_res_b = '0;

  servo_scale_arbiter dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Req_A    (i_Req_A),
    .i_Req_B    (i_Req_B),
    .i_Value_A  (i_Value_A),
    .i_Value_B  (i_Value_B),
    .o_Ack_A    (o_Ack_A),
    .o_Ack_B    (o_Ack_B),
    .o_Div_Start(o_Div_Start),
    .o_Dividend (o_Dividend),
    .o_Divisor  (o_Divisor),
    .i_Div_Done (i_Div_Done),
    .i_Quotient (i_Quotient),
    .o_Result_A (o_Result_A),
    .o_Result_B (o_Result_B),
    .o_Valid_A  (o_Valid_A),
    .o_Valid_B  (o_Valid_B),
    .o_Busy     (o_Busy),
    .o_Timeout  (o_Timeout)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic        req_a;
    logic        req_b;
    logic [7:0]  val_a;
    logic [7:0]  val_b;
    logic [11:0] quot;
    logic        exp_b;
    logic [11:0] exp_div;
    logic [3:0]  exp_res;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return o_Ack_A | o_Ack_B;
      1:       return o_Valid_A | o_Valid_B;
      2:       return o_Timeout;
      default: return o_Div_Start;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (sig(sel)) break;
    end
    if (!sig(sel)) begin
      check({name, "_bound"}, 32'd0, 32'd1);
      n = -1;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_dividend"}, o_Dividend, 0);
    check({name, "_divisor"}, o_Divisor, 0);
    check({name, "_flags"}, {o_Ack_A, o_Ack_B, o_Div_Start, o_Valid_A, o_Valid_B,
                             o_Busy, o_Timeout, o_Result_A, o_Result_B}, 0);
  endtask

  // Divider model: answers with div_q on the cycle after it sees the start pulse.
  initial begin
    forever begin
      @(posedge i_Clk);
      #1;
      if (div_auto && o_Div_Start) begin
        @(posedge i_Clk);
        #1;
        auto_done = 1'b1;
        auto_q    = div_q;
        @(posedge i_Clk);
        #1;
        auto_done = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int m;
    logic seen_valid;
    logic [11:0] seen_div;

    //        reqA  reqB  valA    valB    quot      B?    dividend   result
    vecs[0] = '{1'b1, 1'b1, 8'd0,   8'd180, 12'd0,  1'b0, 12'd0,    4'd0};
    vecs[1] = '{1'b0, 1'b1, 8'd0,   8'd180, 12'd15, 1'b1, 12'd2700, 4'd15};
    vecs[2] = '{1'b1, 1'b1, 8'd90,  8'd180, 12'd7,  1'b0, 12'd1350, 4'd7};
    vecs[3] = '{1'b1, 1'b1, 8'd45,  8'd200, 12'd20, 1'b1, 12'd2700, 4'd15};
    vecs[4] = '{1'b0, 1'b1, 8'd0,   8'd60,  12'd5,  1'b1, 12'd900,  4'd5};
    vecs[5] = '{1'b1, 1'b0, 8'd1,   8'd0,   12'd0,  1'b0, 12'd15,   4'd0};
    vecs[6] = '{1'b1, 1'b1, 8'd179, 8'd10,  12'd0,  1'b1, 12'd150,  4'd0};

    repeat (3) tick();
    check_all_zero("reset");
    i_Rst_L = 1'b1;
    tick();
    check("idle_busy", o_Busy, 0);

    for (int i = 0; i < 7; i++) begin
      div_q     = vecs[i].quot;
      i_Req_A   = vecs[i].req_a;
      i_Req_B   = vecs[i].req_b;
      i_Value_A = vecs[i].val_a;
      i_Value_B = vecs[i].val_b;
      wait_sig($sformatf("v%0d_ack", i), 0, 8, n);
      check($sformatf("v%0d_ack_a", i), o_Ack_A, !vecs[i].exp_b);
      check($sformatf("v%0d_ack_b", i), o_Ack_B, vecs[i].exp_b);
      if (vecs[i].exp_b) i_Req_B = 1'b0;
      else i_Req_A = 1'b0;
      n = 0;
      seen_div = '1;
      while (n < 100 && !(o_Valid_A || o_Valid_B || o_Timeout)) begin
        tick();
        n++;
        if (o_Div_Start) begin
          seen_div = o_Dividend;
          check($sformatf("v%0d_divisor", i), o_Divisor, 180);
          check($sformatf("v%0d_busy", i), o_Busy, 1);
        end
      end
      if (vecs[i].exp_b) exp_res_b = vecs[i].exp_res;
      else exp_res_a = vecs[i].exp_res;
      check($sformatf("v%0d_latency", i), n, 6);
      check($sformatf("v%0d_dividend", i), seen_div, vecs[i].exp_div);
      check($sformatf("v%0d_valid_a", i), o_Valid_A, !vecs[i].exp_b);
      check($sformatf("v%0d_valid_b", i), o_Valid_B, vecs[i].exp_b);
      check($sformatf("v%0d_result_a", i), o_Result_A, exp_res_a);
      check($sformatf("v%0d_result_b", i), o_Result_B, exp_res_b);
    end

    // Back-to-back: B held during A's conversion is granted right after A completes.
    i_Req_B   = 1'b0;
    i_Req_A   = 1'b1;
    i_Value_A = 8'd90;
    div_q     = 12'd7;
    wait_sig("b2b_ack_a", 0, 8, n);
    check("b2b_ack_a", o_Ack_A, 1);
    i_Req_A   = 1'b0;
    i_Req_B   = 1'b1;
    i_Value_B = 8'd60;
    wait_sig("b2b_valid_a", 1, 100, n);
    check("b2b_latency", n, 6);
    check("b2b_valid_a", o_Valid_A, 1);
    exp_res_a = 4'd7;
    check("b2b_result_a", o_Result_A, exp_res_a);
    div_q = 12'd5;
    tick();
    check("b2b_ack_b", o_Ack_B, 1);
    i_Req_B = 1'b0;
    wait_sig("b2b_valid_b", 1, 100, n);
    exp_res_b = 4'd5;
    check("b2b_result_b", o_Result_B, exp_res_b);

    // Divider timeout: no done ever arrives.
    tick();
    div_auto  = 1'b0;
    i_Req_A   = 1'b1;
    i_Value_A = 8'd90;
    wait_sig("to_ack", 0, 8, n);
    i_Req_A = 1'b0;
    n = 0;
    seen_valid = 1'b0;
    while (n < 100 && !o_Timeout) begin
      tick();
      n++;
      if (o_Valid_A || o_Valid_B) seen_valid = 1'b1;
    end
    check("to_latency", n, 67);
    check("to_no_valid", seen_valid, 0);
    check("to_result_a", o_Result_A, exp_res_a);
    check("to_result_b", o_Result_B, exp_res_b);
    tick();
    check("to_single_pulse", o_Timeout, 0);
    check("to_idle", o_Busy, 0);
    man_done = 1'b1;
    man_q    = 12'd3;
    tick();
    man_done = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_Valid_A || o_Valid_B || o_Busy) seen_valid = 1'b1;
    end
    check("late_done_ignored", seen_valid, 0);
    check("late_done_result_a", o_Result_A, exp_res_a);

    // Reset in the middle of WAIT while A keeps requesting.
    i_Req_A   = 1'b1;
    i_Value_A = 8'd30;
    wait_sig("rst_ack", 0, 8, n);
    wait_sig("rst_start", 3, 8, n);
    repeat (3) tick();
    check("rst_in_wait", o_Busy, 1);
    i_Rst_L = 1'b0;
    tick();
    check_all_zero("mid_rst");
    exp_res_a = '0;
    exp_res_b = '0;
    i_Rst_L = 1'b1;
    tick();
    check("rst_regrant", o_Ack_A, 1);
    i_Req_A  = 1'b0;
    man_done = 1'b1;
    man_q    = 12'd9;
    tick();
    man_done = 1'b0;
    div_auto = 1'b1;
    div_q    = 12'd2;
    wait_sig("rst_valid", 1, 100, m);
    check("rst_latency", m + 1, 6);
    check("rst_valid_a", o_Valid_A, 1);
    check("rst_result_a", o_Result_A, 2);
    check("rst_result_b", o_Result_B, exp_res_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
